kvadd_tutorial_example_chunk_scheduler: RTL and testbench

KVADD_TUTORIAL_EXAMPLE_CHUNK_SCHEDULER -- requirements
Module: kvadd_tutorial_example_chunk_scheduler

---
 rtl/kvadd_tutorial_example_pkg.sv | 20 ++
 rtl/kvadd_tutorial_example_watchdog.sv | 41 ++++
 rtl/kvadd_tutorial_example_chunk_scheduler.sv | 154 +++++++++++++++
 tb/tb_kvadd_tutorial_example_chunk_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kvadd_tutorial_example_pkg.sv
// Shared FSM encoding and default sizing for the kvadd chunk scheduler.
// Encodings are kept as plain localparams so legacy code can match on raw values.
package kvadd_tutorial_example_pkg;

  localparam int DEFAULT_CHUNK_BYTES    = 4096;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_LAUNCH = S_LAUNCH,
    ST_WAIT   = S_WAIT,
    ST_DONE   = S_DONE
  } state_e;

endpackage

// File: rtl/kvadd_tutorial_example_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear, expired on the Nth.
// expired is combinational from the count, so the owner can react in the same cycle.
module kvadd_tutorial_example_watchdog
  import kvadd_tutorial_example_pkg::*;
#(
  parameter int C_TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic aclk,
  input  logic areset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(C_TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Holds at LAST so a stuck enable never wraps back to a non-expired value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/kvadd_tutorial_example_chunk_scheduler.sv
// Splits one host transfer into <= C_CHUNK_BYTES datapath jobs, launched one at a time.
// One LAUNCH cycle per chunk, then waits for dp_done or the watchdog; ap_start only sampled in IDLE.
module kvadd_tutorial_example_chunk_scheduler
  import kvadd_tutorial_example_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_CHUNK_BYTES      = DEFAULT_CHUNK_BYTES,
  parameter int C_TIMEOUT_CYCLES   = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          ap_start,
  output logic                          ap_idle,
  output logic                          ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
  input  logic [C_ADDER_BIT_WIDTH-1:0]  ctrl_constant,
  output logic                          dp_start,
  input  logic                          dp_done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] dp_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0]  dp_xfer_size_in_bytes,
  output logic [C_ADDER_BIT_WIDTH-1:0]  dp_constant,
  output logic [C_XFER_SIZE_WIDTH-1:0]  chunk_count,
  output logic                          err_timeout
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int XW = C_XFER_SIZE_WIDTH;
  localparam int KW = C_ADDER_BIT_WIDTH;
  localparam logic [XW-1:0] CHUNK = XW'(C_CHUNK_BYTES);

  function automatic logic [XW-1:0] clip_chunk(input logic [XW-1:0] bytes_left);
    return (bytes_left > CHUNK) ? CHUNK : bytes_left;
  endfunction

  state_e        state_q, state_d;
  logic [XW-1:0] remaining_q, remaining_d;
  logic [AW-1:0] dp_addr_q, dp_addr_d;
  logic [XW-1:0] dp_size_q, dp_size_d;
  logic [KW-1:0] dp_const_q, dp_const_d;
  logic [XW-1:0] chunk_count_q, chunk_count_d;
  logic          err_q, err_d;

  logic [XW-1:0] rem_after;
  logic [AW-1:0] addr_after;
  logic          wd_clear;
  logic          wd_enable;
  logic          wd_expired;

  assign wd_enable = (state_q == ST_WAIT);
  assign wd_clear  = !wd_enable;

  kvadd_tutorial_example_watchdog #(
    .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
  ) u_watchdog (
    .aclk    (aclk),
    .areset  (areset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // The dp_* registers double as the chunk cursor: they only move on entry
  // to LAUNCH, so they stay stable through LAUNCH and WAIT for free.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    dp_addr_d     = dp_addr_q;
    dp_size_d     = dp_size_q;
    dp_const_d    = dp_const_q;
    chunk_count_d = chunk_count_q;
    err_d         = err_q;
    rem_after     = remaining_q - dp_size_q;
    addr_after    = dp_addr_q + AW'(dp_size_q);

    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          remaining_d   = ctrl_xfer_size_in_bytes;
          dp_const_d    = ctrl_constant;
          chunk_count_d = '0;
          err_d         = 1'b0;
          if (ctrl_xfer_size_in_bytes == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_LAUNCH;
            dp_addr_d = ctrl_addr_offset;
            dp_size_d = clip_chunk(ctrl_xfer_size_in_bytes);
          end
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // dp_done is tested first so a completion on the expiry cycle still counts.
        if (dp_done) begin
          remaining_d = rem_after;
          if (chunk_count_q != '1) begin
            chunk_count_d = chunk_count_q + 1'b1;
          end
          if (rem_after != '0) begin
            state_d   = ST_LAUNCH;
            dp_addr_d = addr_after;
            dp_size_d = clip_chunk(rem_after);
          end else begin
            state_d = ST_DONE;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      dp_addr_q     <= '0;
      dp_size_q     <= '0;
      dp_const_q    <= '0;
      chunk_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      dp_addr_q     <= dp_addr_d;
      dp_size_q     <= dp_size_d;
      dp_const_q    <= dp_const_d;
      chunk_count_q <= chunk_count_d;
      err_q         <= err_d;
    end
  end

  assign ap_idle               = (state_q == ST_IDLE);
  assign ap_done               = (state_q == ST_DONE);
  assign dp_start              = (state_q == ST_LAUNCH);
  assign dp_addr_offset        = dp_addr_q;
  assign dp_xfer_size_in_bytes = dp_size_q;
  assign dp_constant           = dp_const_q;
  assign chunk_count           = chunk_count_q;
  assign err_timeout           = err_q;

endmodule

// File: tb/tb_kvadd_tutorial_example_chunk_scheduler.sv
// Bench for the chunk scheduler: transaction-level reference model compared every cycle,
// plus directed scenarios pinned with hand-computed values and randomized jobs.
module tb_kvadd_tutorial_example_chunk_scheduler;

  localparam int AW    = 64;
  localparam int XW    = 32;
  localparam int KW    = 32;
  localparam int CHUNK = 4096;
  localparam int TMO   = 1024;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          ap_start = 1'b0;
  logic          dp_done = 1'b0;
  logic [AW-1:0] ctrl_addr_offset = '0;
  logic [XW-1:0] ctrl_xfer_size_in_bytes = '0;
  logic [KW-1:0] ctrl_constant = '0;
  logic          ap_idle, ap_done, dp_start, err_timeout;
  logic [AW-1:0] dp_addr_offset;
  logic [XW-1:0] dp_xfer_size_in_bytes, chunk_count;
  logic [KW-1:0] dp_constant;

  kvadd_tutorial_example_chunk_scheduler dut (
    .aclk                    (aclk),
    .areset                  (areset),
    .ap_start                (ap_start),
    .ap_idle                 (ap_idle),
    .ap_done                 (ap_done),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .ctrl_constant           (ctrl_constant),
    .dp_start                (dp_start),
    .dp_done                 (dp_done),
    .dp_addr_offset          (dp_addr_offset),
    .dp_xfer_size_in_bytes   (dp_xfer_size_in_bytes),
    .dp_constant             (dp_constant),
    .chunk_count             (chunk_count),
    .err_timeout             (err_timeout)
  );

  initial forever #5 aclk = ~aclk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: bench never reached its summary");
    $fatal(1, "bench timeout");
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: job-level bookkeeping of what the outputs must show.
  bit          m_idle = 1'b1, m_done = 1'b0, m_start = 1'b0, m_err = 1'b0;
  bit          m_waiting = 1'b0;
  int          m_waited = 0;
  logic [31:0] m_rem = '0, m_size = '0, m_const = '0, m_cnt = '0;
  logic [63:0] m_addr = '0;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] size;
    int          c;
  } launch_t;
  launch_t launches[$];
  int n_done = 0;
  int done_cyc = 0;
  int last_dpdone_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_issue(input logic [63:0] a);
    m_addr  = a;
    m_size  = (m_rem < 32'(CHUNK)) ? m_rem : 32'(CHUNK);
    m_start = 1'b1;
  endtask

  task automatic model_update();
    if (areset) begin
      m_idle = 1'b1; m_done = 1'b0; m_start = 1'b0; m_err = 1'b0;
      m_waiting = 1'b0; m_waited = 0;
      m_rem = '0; m_size = '0; m_const = '0; m_cnt = '0; m_addr = '0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_idle = 1'b1;
    end else if (m_idle) begin
      if (ap_start) begin
        m_idle  = 1'b0;
        m_const = ctrl_constant;
        m_cnt   = '0;
        m_err   = 1'b0;
        m_rem   = ctrl_xfer_size_in_bytes;
        if (m_rem == 0) m_done = 1'b1;
        else model_issue(ctrl_addr_offset);
      end
    end else if (m_start) begin
      m_start   = 1'b0;
      m_waiting = 1'b1;
      m_waited  = 0;
    end else if (m_waiting) begin
      m_waited++;
      if (dp_done) begin
        m_rem = m_rem - m_size;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_waiting = 1'b0;
        if (m_rem != 0) model_issue(m_addr + 64'(m_size));
        else m_done = 1'b1;
      end else if (m_waited == TMO) begin
        m_err     = 1'b1;
        m_waiting = 1'b0;
        m_done    = 1'b1;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [163:0] act, exp;
    act = {ap_idle, ap_done, dp_start, err_timeout, dp_addr_offset,
           dp_xfer_size_in_bytes, dp_constant, chunk_count};
    exp = {m_idle, m_done, m_start, m_err, m_addr, m_size, m_const, m_cnt};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cycle_%0d_outputs: got %h, expected %h", cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    model_update();
    cyc++;
    #1;
    compare_outputs();
  endtask

  task automatic start_job(input logic [63:0] a, input logic [31:0] s, input logic [31:0] k);
    int guard;
    guard = 0;
    while (!ap_idle && guard < 50) begin
      step();
      guard++;
    end
    checki("idle_before_start", int'(ap_idle), 1);
    ctrl_addr_offset        = a;
    ctrl_xfer_size_in_bytes = s;
    ctrl_constant           = k;
    ap_start                = 1'b1;
    launches.delete();
    n_done = 0;
    step();
    ap_start = 1'b0;
  endtask

  // Acts as the datapath: answers each dp_start after a random delay in [dmin,dmax].
  task automatic run_job(input int dmin, input int dmax, input bit respond,
                         input bit noise, input int budget);
    int since, delay;
    bit fin;
    since = -1; delay = 0; fin = 1'b0;
    for (int c = 0; c < budget && !fin; c++) begin
      if (ap_done) begin
        fin = 1'b1;
        n_done++;
        done_cyc = cyc;
        ap_start = 1'b0;
        dp_done  = 1'b0;
      end else begin
        if (dp_start) begin
          since = 0;
          delay = int'($urandom_range(dmax, dmin));
          launches.push_back('{dp_addr_offset, dp_xfer_size_in_bytes, cyc});
        end else if (since >= 0) begin
          since++;
        end
        if (respond && since == delay && !dp_start) begin
          dp_done = 1'b1;
          last_dpdone_cyc = cyc;
        end else if (noise && dp_start) begin
          dp_done = 1'($urandom_range(1, 0));
        end else begin
          dp_done = 1'b0;
        end
        if (noise) ap_start = 1'($urandom_range(1, 0));
        step();
      end
    end
    if (!fin) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_job_budget: no ap_done within %0d cycles", budget);
      ap_start = 1'b0;
      dp_done  = 1'b0;
    end
  endtask

  initial begin
    int bad, seen, since, s, nexp, sum;
    logic [63:0] a;
    logic [63:0] exp_addr [3];
    int          exp_size [3];

    repeat (3) step();
    checki("reset_ap_idle", int'(ap_idle), 1);
    checki("reset_ap_done", int'(ap_done), 0);
    checki("reset_dp_start", int'(dp_start), 0);
    checki("reset_err", int'(err_timeout), 0);
    check("reset_dp_addr", dp_addr_offset, 64'h0);
    checki("reset_chunk_count", int'(chunk_count), 0);
    areset = 1'b0;
    step();

    // Three-chunk transfer with a fixed 20-cycle datapath.
    exp_addr = '{64'h1000, 64'h2000, 64'h3000};
    exp_size = '{4096, 4096, 1808};
    start_job(64'h1000, 32'd10000, 32'hCAFE_0001);
    run_job(20, 20, 1'b1, 1'b0, 500);
    checki("t1_launch_count", launches.size(), 3);
    for (int i = 0; i < 3 && i < launches.size(); i++) begin
      check($sformatf("t1_launch%0d_addr", i), launches[i].addr, exp_addr[i]);
      checki($sformatf("t1_launch%0d_size", i), int'(launches[i].size), exp_size[i]);
    end
    if (launches.size() >= 2) checki("t1_launch_spacing", launches[1].c - launches[0].c, 21);
    checki("t1_done_pulses", n_done, 1);
    checki("t1_chunk_count", int'(chunk_count), 3);
    checki("t1_err", int'(err_timeout), 0);
    step();
    checki("t1_done_single_cycle", int'(ap_done), 0);

    // Zero-byte job completes the cycle after acceptance with no launch.
    start_job(64'h4000, 32'd0, 32'h0000_0002);
    checki("t2_done_next_cycle", int'(ap_done), 1);
    checki("t2_no_dp_start", int'(dp_start), 0);
    checki("t2_chunk_count", int'(chunk_count), 0);
    step();
    checki("t2_back_to_idle", int'(ap_idle), 1);

    // Exactly one chunk at the top of the address space.
    start_job(64'hFFFF_FFFF_FFFF_F000, 32'd4096, 32'h0000_0003);
    run_job(5, 5, 1'b1, 1'b0, 200);
    checki("t3_launch_count", launches.size(), 1);
    if (launches.size() > 0) begin
      check("t3_addr", launches[0].addr, 64'hFFFF_FFFF_FFFF_F000);
      checki("t3_size", int'(launches[0].size), 4096);
    end
    checki("t3_done_after_dp_done", done_cyc - last_dpdone_cyc, 1);
    bad = 0;
    repeat (3) begin step(); bad += int'(dp_start); end
    checki("t3_no_extra_launch", bad, 0);

    // dp_done on the very cycle the watchdog expires still completes the chunk.
    start_job(64'h9000, 32'd4096, 32'h0000_0004);
    run_job(TMO, TMO, 1'b1, 1'b0, 2000);
    checki("t4_tie_err", int'(err_timeout), 0);
    checki("t4_tie_chunk_count", int'(chunk_count), 1);

    // Withheld dp_done trips the watchdog after 1024 WAIT cycles.
    start_job(64'hA000, 32'd8192, 32'h0000_0005);
    run_job(0, 0, 1'b0, 1'b0, 3000);
    checki("t5_err", int'(err_timeout), 1);
    checki("t5_chunk_count", int'(chunk_count), 0);
    checki("t5_done_pulses", n_done, 1);
    checki("t5_launch_count", launches.size(), 1);
    checki("t5_wait_length", done_cyc - (launches.size() > 0 ? launches[0].c : 0), TMO + 1);
    start_job(64'h0, 32'd0, 32'h0000_0006);
    checki("t5_err_cleared_by_start", int'(err_timeout), 0);

    // ap_start held through DONE is accepted again in the following IDLE cycle.
    start_job(64'h0, 32'd0, 32'h0000_0007);
    ap_start = 1'b1;
    checki("t6_first_done", int'(ap_done), 1);
    step();
    checki("t6_idle_between", int'(ap_idle), 1);
    step();
    checki("t6_second_done", int'(ap_done), 1);
    ap_start = 1'b0;
    step();

    // Reset in the middle of the second chunk's WAIT aborts the job.
    start_job(64'h8000, 32'd10000, 32'h0000_0008);
    seen = 0; since = -1;
    for (int c = 0; c < 200 && seen < 2; c++) begin
      if (dp_start) begin seen++; since = 0; end
      else if (since >= 0) since++;
      dp_done = (since == 3 && seen < 2);
      step();
    end
    dp_done = 1'b0;
    checki("t7_reached_second_launch", seen, 2);
    repeat (4) step();
    areset = 1'b1;
    step();
    areset = 1'b0;
    checki("t7_rst_idle", int'(ap_idle), 1);
    checki("t7_rst_done", int'(ap_done), 0);
    checki("t7_rst_dp_start", int'(dp_start), 0);
    check("t7_rst_addr", dp_addr_offset, 64'h0);
    checki("t7_rst_size", int'(dp_xfer_size_in_bytes), 0);
    checki("t7_rst_const", int'(dp_constant), 0);
    checki("t7_rst_chunk_count", int'(chunk_count), 0);
    dp_done = 1'b1;
    step();
    dp_done = 1'b0;
    bad = 0;
    repeat (10) begin step(); bad += int'(ap_done) + int'(dp_start) + int'(!ap_idle); end
    checki("t7_late_dp_done_ignored", bad, 0);

    // Stray dp_done in IDLE; then ap_start/dp_done noise outside their windows.
    dp_done = 1'b1;
    step();
    dp_done = 1'b0;
    bad = 0;
    repeat (3) begin step(); bad += int'(dp_start) + int'(!ap_idle); end
    checki("t8_idle_dp_done_ignored", bad, 0);
    start_job(64'hB000, 32'd9000, 32'h0000_0009);
    run_job(1, 30, 1'b1, 1'b1, 1000);
    checki("t8_noise_launch_count", launches.size(), 3);
    checki("t8_noise_done_pulses", n_done, 1);

    // Randomized jobs; the per-cycle compare carries most of the checking.
    for (int j = 0; j < 25; j++) begin
      case ($urandom_range(3, 0))
        0: s = 0;
        1: s = CHUNK * int'($urandom_range(4, 1));
        2: s = int'($urandom_range(20000, 1));
        default: s = int'($urandom_range(64, 1));
      endcase
      if ($urandom_range(1, 0) == 1) a = 64'hFFFF_FFFF_FFFF_0000 + 64'($urandom_range(65535, 0));
      else a = {$urandom, $urandom};
      start_job(a, 32'(s), $urandom);
      run_job(1, 40, 1'b1, 1'b1, 5000);
      nexp = (s + CHUNK - 1) / CHUNK;
      sum = 0;
      foreach (launches[i]) sum += int'(launches[i].size);
      checki($sformatf("rnd%0d_launch_count", j), launches.size(), nexp);
      checki($sformatf("rnd%0d_bytes_total", j), sum, s);
      checki($sformatf("rnd%0d_chunk_count", j), int'(chunk_count), nexp);
      if (launches.size() > 0) check($sformatf("rnd%0d_first_addr", j), launches[0].addr, a);
    end

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
